// File: rtl/mem_access_unit.sv
// Load/store stage in front of the data memory: registers one request, drives the
// memory port from that register, and returns an extended load result one edge later.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [31:0]       in_pc,
  input  logic [4:0]        in_rd,
  output logic [31:0]       mem_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [4:0]        out_rd,
  output logic [31:0]       out_pc,
  output logic              out_exc,
  output logic              out_exc_store,
  output logic [ADDR_W-1:0] out_badvaddr
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  logic              s1Valid;
  logic [2:0]        s1Op;
  logic [ADDR_W-1:0] s1Addr;
  logic [31:0]       s1Wdata;
  logic [31:0]       s1Pc;
  logic [4:0]        s1Rd;

  logic [1:0]  lane;
  logic        isStore;
  logic        isHalf;
  logic        isWord;
  logic        misaligned;
  logic        adv;
  logic        accept;
  logic        storeFire;
  logic [3:0]  storeWe;
  logic [31:0] storeData;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] resultData;

  assign lane    = s1Addr[1:0];
  assign isStore = (s1Op == OP_SB) || (s1Op == OP_SH) || (s1Op == OP_SW);
  assign isHalf  = (s1Op == OP_LH) || (s1Op == OP_LHU) || (s1Op == OP_SH);
  assign isWord  = (s1Op == OP_LW) || (s1Op == OP_SW);

  assign misaligned = (isHalf && lane[0]) || (isWord && (lane != 2'b00));

  assign adv      = s1Valid && (!out_valid || out_ready);
  assign in_ready = !s1Valid || adv;
  assign accept   = in_valid && in_ready;

  // Gating on adv makes each store write exactly once, on the edge it leaves S1.
  assign storeFire = adv && !misaligned && !flush && isStore && Reset_n;

  always_comb begin
    storeWe   = 4'b0000;
    storeData = s1Wdata;
    case (s1Op)
      OP_SB: begin
        storeWe   = 4'b0001 << lane;
        storeData = {4{s1Wdata[7:0]}};
      end
      OP_SH: begin
        storeWe   = lane[1] ? 4'b1100 : 4'b0011;
        storeData = {2{s1Wdata[15:0]}};
      end
      OP_SW: begin
        storeWe   = 4'b1111;
        storeData = s1Wdata;
      end
      default: begin
        storeWe   = 4'b0000;
        storeData = s1Wdata;
      end
    endcase
  end

  assign mem_addr  = s1Addr;
  assign mem_pc    = s1Pc;
  assign mem_wdata = storeData;
  assign mem_we    = storeFire ? storeWe : 4'b0000;

  always_comb begin
    loadByte = mem_rdata[7:0];
    case (lane)
      2'd0: loadByte = mem_rdata[7:0];
      2'd1: loadByte = mem_rdata[15:8];
      2'd2: loadByte = mem_rdata[23:16];
      2'd3: loadByte = mem_rdata[31:24];
      default: loadByte = mem_rdata[7:0];
    endcase
  end

  assign loadHalf = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  // Stores and faulting ops report zero data so writeback never sees stale lanes.
  always_comb begin
    resultData = 32'd0;
    if (!misaligned) begin
      case (s1Op)
        OP_LB:   resultData = {{24{loadByte[7]}}, loadByte};
        OP_LBU:  resultData = {24'd0, loadByte};
        OP_LH:   resultData = {{16{loadHalf[15]}}, loadHalf};
        OP_LHU:  resultData = {16'd0, loadHalf};
        OP_LW:   resultData = mem_rdata;
        default: resultData = 32'd0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1Valid <= 1'b0;
      s1Op    <= OP_LB;
      s1Addr  <= '0;
      s1Wdata <= 32'd0;
      s1Pc    <= 32'd0;
      s1Rd    <= 5'd0;
    end else if (flush) begin
      s1Valid <= 1'b0;
    end else if (accept) begin
      s1Valid <= 1'b1;
      s1Op    <= in_op;
      s1Addr  <= in_addr;
      s1Wdata <= in_wdata;
      s1Pc    <= in_pc;
      s1Rd    <= in_rd;
    end else if (adv) begin
      s1Valid <= 1'b0;
    end
  end

  // S2 holds still under backpressure and empties once writeback takes it with nothing behind.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid     <= 1'b0;
      out_data      <= 32'd0;
      out_rd        <= 5'd0;
      out_pc        <= 32'd0;
      out_exc       <= 1'b0;
      out_exc_store <= 1'b0;
      out_badvaddr  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid     <= 1'b1;
      out_data      <= resultData;
      out_rd        <= (isStore || misaligned) ? 5'd0 : s1Rd;
      out_pc        <= s1Pc;
      out_exc       <= misaligned;
      out_exc_store <= misaligned && isStore;
      out_badvaddr  <= misaligned ? s1Addr : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random traffic, scored against a
// byte-array memory model and an in-order expected-result queue.
module tb_mem_access_unit;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  logic        Clk;
  logic        Reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [31:0] in_pc;
  logic [4:0]  in_rd;
  logic [31:0] mem_pc;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        out_exc;
  logic        out_exc_store;
  logic [31:0] out_badvaddr;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        exc;
    logic        excStore;
    logic [31:0] badAddr;
    bit          checkLat;
    int          accCycle;
  } expT;

  expT         scoreQ[$];
  logic [31:0] memWords [0:255];
  logic [7:0]  refBytes [0:1023];
  int          checks;
  int          errors;
  int          cycleCount;
  int          acceptCount;
  logic [31:0] pcCounter;
  bit          readyMode;
  bit          readyForce;

  mem_access_unit #(.ADDR_W(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_pc(in_pc), .in_rd(in_rd),
    .mem_pc(mem_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_pc(out_pc), .out_exc(out_exc), .out_exc_store(out_exc_store),
    .out_badvaddr(out_badvaddr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cycleCount <= cycleCount + 1;

  function automatic logic [31:0] mergeWord(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] we);
    logic [31:0] w;
    w = old;
    for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  assign mem_rdata = memWords[mem_addr[9:2]];

  always @(posedge Clk)
    if (mem_we != 4'b0000)
      memWords[mem_addr[9:2]] <= mergeWord(memWords[mem_addr[9:2]], mem_wdata, mem_we);

  function automatic logic [31:0] refWord(input int w);
    return {refBytes[4*w+3], refBytes[4*w+2], refBytes[4*w+1], refBytes[4*w]};
  endfunction

  // Reference: an op touches `size` little-endian bytes at addr; misaligned if addr % size != 0.
  function automatic expT modelOp(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] pc,
                                  input logic [4:0] rd);
    expT         e;
    int          size;
    bit          store;
    logic [31:0] v;
    int          base;
    store = (op >= OP_SB);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) size = 1;
    else if (op == OP_LH || op == OP_LHU || op == OP_SH) size = 2;
    else size = 4;
    base       = int'(addr[9:0]);
    e.pc       = pc;
    e.exc      = (int'(addr[1:0]) % size) != 0;
    e.excStore = e.exc && store;
    e.badAddr  = addr;
    e.data     = 32'd0;
    e.rd       = 5'd0;
    e.checkLat = 1'b0;
    e.accCycle = 0;
    if (!e.exc) begin
      if (store) begin
        for (int i = 0; i < size; i++) refBytes[base + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(refBytes[base + i]) << (8 * i));
        if (op == OP_LB && v[7]) v = v | 32'hFFFF_FF00;
        if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
        e.data = v;
        e.rd   = rd;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Issues one request and records its expected result at the moment it is accepted.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit lat);
    expT e;
    bit  done;
    int  waited;
    logic [4:0] rd;
    rd     = 5'($urandom);
    done   = 1'b0;
    waited = 0;
    pcCounter = pcCounter + 32'd4;
    @(negedge Clk);
    in_op    = op;
    in_addr  = addr;
    in_wdata = wdata;
    in_pc    = pcCounter;
    in_rd    = rd;
    in_valid = 1'b1;
    while (!done) begin
      #2;
      if (in_ready) begin
        e          = modelOp(op, addr, wdata, pcCounter, rd);
        e.checkLat = lat;
        e.accCycle = cycleCount;
        scoreQ.push_back(e);
        @(posedge Clk);
        acceptCount++;
        #1 in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(posedge Clk);
        waited++;
        if (waited > 50) begin
          checkOutput("accept_timeout", 32'(in_ready), 32'd1);
          #1 in_valid = 1'b0;
          done = 1'b1;
        end else begin
          @(negedge Clk);
        end
      end
    end
  endtask

  task automatic checkWe(input string name, input logic [3:0] expWe);
    @(negedge Clk);
    #1 checkOutput(name, 32'(mem_we), 32'(expWe));
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (scoreQ.size() != 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    checkOutput("drain_empty", 32'(scoreQ.size()), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  // Monitor: chooses out_ready, then scores every handshake against the queue head.
  initial begin
    expT e;
    out_ready = 1'b1;
    forever begin
      @(negedge Clk);
      out_ready = readyMode ? ($urandom_range(0, 3) != 0) : readyForce;
      #1;
      if (Reset_n && out_valid && out_ready) begin
        if (scoreQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out actual pc=%h expected none", out_pc);
        end else begin
          e = scoreQ.pop_front();
          checkOutput("out_pc", out_pc, e.pc);
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_rd", 32'(out_rd), 32'(e.rd));
          checkOutput("out_exc", 32'(out_exc), 32'(e.exc));
          checkOutput("out_exc_store", 32'(out_exc_store), 32'(e.excStore));
          if (e.exc) checkOutput("out_badvaddr", out_badvaddr, e.badAddr);
          if (e.checkLat) checkOutput("latency", 32'(cycleCount - e.accCycle), 32'd2);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] snapData;
    logic [31:0] snapPc;
    int          base;
    checks = 0; errors = 0; cycleCount = 0; acceptCount = 0;
    pcCounter = 32'h0000_1000;
    readyMode = 1'b0; readyForce = 1'b1;
    Reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_op = OP_LB; in_addr = 32'd0; in_wdata = 32'd0; in_pc = 32'd0; in_rd = 5'd0;
    for (int w = 0; w < 256; w++) begin
      memWords[w] = $urandom;
      for (int b = 0; b < 4; b++) refBytes[4*w + b] = memWords[w][8*b +: 8];
    end

    repeat (2) @(negedge Clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_rd", 32'(out_rd), 32'd0);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_exc", 32'(out_exc), 32'd0);
    checkOutput("rst_out_exc_store", 32'(out_exc_store), 32'd0);
    checkOutput("rst_out_badvaddr", out_badvaddr, 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);
    #1 checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    // Reset arrives while a SW sits in S1 about to write.
    @(negedge Clk);
    in_op = OP_SW; in_addr = 32'h10; in_wdata = 32'hDEAD_BEEF; in_pc = 32'h40; in_valid = 1'b1;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    @(negedge Clk);
    #1 checkOutput("sw_we_armed", 32'(mem_we), 32'hF);
    Reset_n = 1'b0;
    #1 checkOutput("reset_we_kill", 32'(mem_we), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_no_write", memWords[4], refWord(4));

    applyStimulus(OP_SB, 32'h21, 32'h0000_00AB, 1'b1);
    @(negedge Clk);
    #1;
    checkOutput("sb_we", 32'(mem_we), 32'h2);
    checkOutput("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    applyStimulus(OP_LB, 32'h21, 32'd0, 1'b1);
    applyStimulus(OP_LBU, 32'h21, 32'd0, 1'b1);
    applyStimulus(OP_SH, 32'h42, 32'h1234_8001, 1'b1);
    @(negedge Clk);
    #1;
    checkOutput("sh_we", 32'(mem_we), 32'hC);
    checkOutput("sh_wdata", mem_wdata, 32'h8001_8001);
    applyStimulus(OP_LH, 32'h42, 32'd0, 1'b1);
    applyStimulus(OP_LW, 32'h40, 32'd0, 1'b1);
    applyStimulus(OP_LW, 32'h13, 32'd0, 1'b1);
    applyStimulus(OP_SH, 32'h15, 32'h5555_AAAA, 1'b1);
    checkWe("sh_mis_no_write", 4'b0000);
    waitDrain();

    // Backpressure: four loads against a stalled writeback.
    readyForce = 1'b0;
    base = acceptCount;
    fork
      begin
        for (int i = 0; i < 4; i++) applyStimulus(OP_LW, 32'h80 + 32'(4 * i), 32'd0, 1'b0);
      end
      begin
        wait (acceptCount == base + 2);
        @(negedge Clk);
        #2;
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        snapData = out_data;
        snapPc   = out_pc;
        for (int k = 0; k < 2; k++) begin
          @(negedge Clk);
          #2;
          checkOutput("bp_hold_data", out_data, snapData);
          checkOutput("bp_hold_pc", out_pc, snapPc);
          checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge Clk);
        #1 readyForce = 1'b1;
      end
    join
    waitDrain();

    // Flush lands while a SW is advancing out of S1; a same-cycle request must vanish too.
    @(negedge Clk);
    in_op = OP_SW; in_addr = 32'h8; in_wdata = 32'hCAFE_F00D; in_pc = 32'h80; in_valid = 1'b1;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    @(negedge Clk);
    flush = 1'b1;
    in_op = OP_LW; in_addr = 32'h0; in_valid = 1'b1;
    #1 checkOutput("flush_we_kill", 32'(mem_we), 32'd0);
    @(posedge Clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge Clk);
    #1;
    checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    @(negedge Clk);
    #1;
    checkOutput("flush_drop_out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_no_write", memWords[2], refWord(2));

    readyMode = 1'b1;
    for (int n = 0; n < 150; n++) begin
      applyStimulus(3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)), $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) @(posedge Clk);
    end
    @(posedge Clk);
    #1;
    readyMode = 1'b0;
    readyForce = 1'b1;
    waitDrain();

    for (int w = 0; w < 256; w++) checkOutput("mem_word", memWords[w], refWord(w));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
